// File: rtl/image_writer_pkg.sv
// Shared types for the framebuffer image loader: pixel layout, FSM states
// and the order in which colour bytes arrive on the stream.
package image_writer_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV_R   = 3'd1,
    RECV_G   = 3'd2,
    RECV_B   = 3'd3,
    WRITE    = 3'd4,
    RECV_SUM = 3'd5,
    FINISH   = 3'd6
  } state_t;

  localparam int BYTE_R          = 0;
  localparam int BYTE_G          = 1;
  localparam int BYTE_B          = 2;
  localparam int BYTES_PER_PIXEL = 3;

endpackage

// File: rtl/image_writer.sv
// Streams R,G,B bytes into 24-bit pixels and writes them to framebuffer addresses 0..H_RES*V_RES-1.
// IMAGE_WRITER_CHECKSUM_EN adds a trailing XOR checksum byte and the chk_err flag.
module image_writer
  import image_writer_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk_25,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              chk_err
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  pixel_t            px_q, px_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              in_ready_q, wr_en_q, busy_q, frame_done_q;
  logic              accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    px_d      = px_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RECV_R;
          cnt_d   = '0;
        end
      end
      RECV_R: begin
        if (accept) begin
          px_d.r  = in_data;
          state_d = RECV_G;
        end
      end
      RECV_G: begin
        if (accept) begin
          px_d.g  = in_data;
          state_d = RECV_B;
        end
      end
      RECV_B: begin
        if (accept) begin
          px_d.b    = in_data;
          wr_addr_d = cnt_q;
          wr_data_d = {px_q.r, px_q.g, in_data};
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_PIX) begin
`ifdef IMAGE_WRITER_CHECKSUM_EN
          state_d = RECV_SUM;
`else
          state_d = FINISH;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RECV_R;
        end
      end
`ifdef IMAGE_WRITER_CHECKSUM_EN
      RECV_SUM: begin
        if (accept) state_d = FINISH;
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything; a WRITE already on the port still completes.
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      px_q         <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      px_q         <= px_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      // Outputs are registered decodes of the state being entered.
      in_ready_q   <= (state_d == RECV_R) || (state_d == RECV_G) ||
                      (state_d == RECV_B) || (state_d == RECV_SUM);
      wr_en_q      <= (state_d == WRITE);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == FINISH);
    end
  end

`ifdef IMAGE_WRITER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic       chk_err_q, chk_err_d;

  always_comb begin
    xor_d     = xor_q;
    chk_err_d = chk_err_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          xor_d     = '0;
          chk_err_d = 1'b0;
        end
      end
      RECV_R, RECV_G, RECV_B: begin
        if (accept) xor_d = xor_q ^ in_data;
      end
      RECV_SUM: begin
        if (accept && !abort) chk_err_d = (in_data != xor_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      xor_q     <= xor_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_image_writer.sv
// Randomised self-checking bench for image_writer on a 4x2 frame; the expected
// framebuffer contents are built directly from the byte payload.
module tb_image_writer;
  import image_writer_pkg::*;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 3;
  localparam int NPIX = H * V;
  localparam int NPAY = NPIX * BYTES_PER_PIXEL;
`ifdef IMAGE_WRITER_CHECKSUM_EN
  localparam int NBYTES = NPAY + 1;
`else
  localparam int NBYTES = NPAY;
`endif
  localparam int BUDGET = 400;

  logic          clk_25 = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, wr_en, busy, frame_done, chk_err;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;

  image_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk_25(clk_25), .n_rst(n_rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .chk_err(chk_err)
  );

  always #5 clk_25 = ~clk_25;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  pay [NBYTES];
  int          got_addr[$];
  int          got_data[$];
  int          got_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          rdy_viol = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Write monitor: records every framebuffer write and frame_done pulse.
  always @(negedge clk_25) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(int'(wr_data));
      got_cyc.push_back(cyc);
      if (in_ready) rdy_viol <= rdy_viol + 1;
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cnt = 0;
    rdy_viol = 0;
  endtask

  // cs_mode: 0 correct checksum, 1 corrupted checksum
  task automatic make_payload(input bit ramp, input bit bad_sum);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < NPAY; i++) begin
      pay[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
      x ^= pay[i];
    end
`ifdef IMAGE_WRITER_CHECKSUM_EN
    pay[NPAY] = bad_sum ? (x ^ 8'hFF) : x;
`else
    if (bad_sum) x = '0;
`endif
  endtask

  task automatic start_frame();
    @(negedge clk_25);
    start = 1'b1;
    @(negedge clk_25);
    start = 1'b0;
  endtask

  // mode 0: valid held high, 1: toggling, 2: random. Call at a negedge.
  task automatic stream(input int nbytes, input int mode, input int mid_start_cyc);
    int idx;
    int c;
    bit acc;
    idx = 0;
    c = 0;
    while (idx < nbytes && c < BUDGET) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (c % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = pay[idx];
      start = (c == mid_start_cyc);
      acc = in_valid && in_ready;
      @(posedge clk_25);
      if (acc) idx++;
      @(negedge clk_25);
      c++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (c >= BUDGET) check("stream_timeout", 32'(idx), 32'(nbytes));
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (done_cnt == 0 && c < 50) begin
      @(negedge clk_25);
      c++;
    end
    if (done_cnt == 0) check("done_timeout", 32'(done_cnt), 32'd1);
    repeat (2) @(negedge clk_25);
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = got_addr.size();
    check({tag, "_nwrites"}, 32'(n), 32'(NPIX));
    for (int p = 0; p < NPIX && p < n; p++) begin
      check({tag, "_addr"}, 32'(got_addr[p]), 32'(p));
      check({tag, "_data"}, 32'(got_data[p]),
            {8'h00, pay[p*3+BYTE_R], pay[p*3+BYTE_G], pay[p*3+BYTE_B]});
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
`ifndef IMAGE_WRITER_CHECKSUM_EN
    if (n > 0) check({tag, "_done_lat"}, 32'(done_cyc - got_cyc[n-1]), 32'd1);
`endif
    check({tag, "_rdy_in_write"}, 32'(rdy_viol), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int mode, input int mid_start, input bit bad_sum);
    clear_log();
    start_frame();
    stream(NBYTES, mode, mid_start);
    wait_done();
    check_frame(tag);
`ifdef IMAGE_WRITER_CHECKSUM_EN
    check({tag, "_chk_err"}, 32'(chk_err), 32'(bad_sum));
`endif
  endtask

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);
    @(negedge clk_25);
    n_rst = 1'b1;

    make_payload(1'b1, 1'b0);
    run_frame("ramp_full", 0, -1, 1'b0);

    make_payload(1'b0, 1'b1);
    run_frame("rand_toggle", 1, -1, 1'b1);
`ifdef IMAGE_WRITER_CHECKSUM_EN
    repeat (5) @(negedge clk_25);
    check("chk_err_held", 32'(chk_err), 32'd1);
`endif

    make_payload(1'b0, 1'b0);
    run_frame("rand_valid", 2, -1, 1'b0);

    // Abort with the second pixel's WRITE on the port.
    make_payload(1'b0, 1'b0);
    clear_log();
    start_frame();
    stream(6, 0, -1);
    abort = 1'b1;
    @(negedge clk_25);
    abort = 1'b0;
    repeat (3) @(negedge clk_25);
    check("abort_nwrites", 32'(got_addr.size()), 32'd2);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done_cnt), 32'd0);
    make_payload(1'b0, 1'b0);
    run_frame("after_abort", 2, -1, 1'b0);

    // Simultaneous start and abort while idle.
    @(negedge clk_25);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_25);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk_25);
    check("start_abort_busy2", 32'(busy), 32'd0);

    make_payload(1'b0, 1'b0);
    run_frame("mid_start", 0, 10, 1'b0);

    // Asynchronous reset while waiting for a G byte.
    make_payload(1'b0, 1'b0);
    clear_log();
    start_frame();
    stream(4, 0, -1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    check("arst_wr_data", 32'(wr_data), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk_25);
    n_rst = 1'b1;
    check("arst_no_done", 32'(done_cnt), 32'd0);
    make_payload(1'b0, 1'b0);
    run_frame("after_rst", 2, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/image_writer.md
Name: image_writer

Overview:
- Loads a full-resolution RGB frame into the framebuffer memory from a byte stream, e.g. a UART receiver.
- Upstream of the framebuffer memory: it drives the memory's write port, while the VGA read path continues to fetch pixels independently.
- Packs R, G, B bytes into 24-bit pixels and writes them to linear addresses 0 to H_RES*V_RES-1.
- Sequencing is controlled by start/abort, with a frame_done pulse at the end.

Parameters:
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines per frame.
- ADDR_W, 19: write address width; must satisfy 2**ADDR_W >= H_RES*V_RES.

Ports:
- clk_25  input  1  25 MHz pixel clock.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a frame load.
- abort  input  1  synchronous cancel of the load in progress.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data, in order R, G, B per pixel.
- in_ready  output  1  byte-stream ready.
- wr_en  output  1  framebuffer write strobe.
- wr_addr  output  ADDR_W  framebuffer write address.
- wr_data  output  24  pixel {R[23:16], G[15:8], B[7:0]}.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse when a frame load completes.
- chk_err  output  1  checksum mismatch flag.

Behaviour:
- Clock and reset: one clock, clk_25. Reset is asynchronous and active-low on n_rst. All flops clear on n_rst low.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, chk_err=0. State = IDLE, pixel counter = 0.
- Handshake: a byte is accepted on a clk_25 edge where in_valid && in_ready. in_ready is a registered state decode: high only in RECV_R, RECV_G, RECV_B (and RECV_SUM).
- IDLE:
  - start=1 -> RECV_R next cycle; pixel counter=0 and chk_err=0 on the same edge.
  - Otherwise stay in IDLE.
- RECV_R / RECV_G / RECV_B:
  - On byte acceptance, latch the byte into its colour field and advance R->G->B->WRITE.
  - No acceptance: hold state indefinitely; there is no timeout.
- WRITE (exactly 1 cycle, in_ready=0):
  - wr_en=1, wr_addr=pixel counter, wr_data={R,G,B}.
  - Next state: if counter == H_RES*V_RES-1 -> FINISH (or RECV_SUM with the optional feature); else counter+1 and -> RECV_R.
- Write latency: wr_en asserts the cycle after the B byte is accepted. Peak throughput is 1 pixel per 4 cycles.
- FINISH (1 cycle): frame_done=1 -> IDLE. wr_en is 0 in every state except WRITE.
- abort: in any non-IDLE state, abort=1 -> IDLE next edge.
  - No frame_done; partial writes remain in memory.
  - A WRITE cycle coincident with abort still performs its write.
- Simultaneous start and abort in IDLE: abort wins; stay in IDLE.
- start while busy: ignored.
- Counter: counts 0 to H_RES*V_RES-1 and never wraps past the last pixel; ADDR_W bits wide, comparison done at full width.
- Reset mid-frame: immediate return to the reset values; no frame_done.

Optional Feature:
- Macro: IMAGE_WRITER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers every accepted pixel byte; it clears on start.
  - After the last WRITE, state RECV_SUM accepts one more byte (in_ready=1).
  - On acceptance, chk_err <= (byte != xor), held until the next start, and the state moves to FINISH.
  - frame_done fires after the checksum byte.
- Undefined: no RECV_SUM state, no XOR logic, and chk_err tied to 0.

Decomposition:
- Package image_writer_pkg:
  - pixel_t (24-bit packed struct r/g/b).
  - state_t enum {IDLE, RECV_R, RECV_G, RECV_B, WRITE, RECV_SUM, FINISH}.
  - Byte-order constants.
- Single module; no sub-module is warranted. The byte-packing is three registers inside the FSM.

Test Plan:
- H_RES=4, V_RES=2; start, then 24 bytes streaming back-to-back with in_valid held 1 -> 8 writes at addr 0..7; addr 0 data = bytes 0,1,2 packed as 0x000102 for payload 0x00..0x17; frame_done is a single pulse 1 cycle after the addr 7 write; busy drops with it.
- Same frame with in_valid toggled 1/0 every cycle -> identical writes and data; no byte lost or duplicated; in_ready=0 during each WRITE.
- Abort after 2 pixels -> only addr 0,1 written; state IDLE; no frame_done. A new start then writes from addr 0 again.
- start and abort asserted together in IDLE -> busy stays 0. start pulsed mid-frame -> counter unaffected.
- n_rst low mid RECV_G -> all outputs 0 asynchronously. After release, the next start loads a clean frame from addr 0.
- With IMAGE_WRITER_CHECKSUM_EN, payload 0x00..0x17:
  - Checksum byte 0x00 (correct XOR) -> chk_err=0.
  - Checksum byte 0xFF -> chk_err=1, held until the next start.
  - In both cases frame_done fires after the checksum byte.
